// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch: one-outstanding imem handshake feeding a {pc, instr} FIFO to decode
module ifetch_unit #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              pc_in,
    input  logic                       flush,
    output logic                       fetch_stall,
    output logic                       imem_req,
    output logic [AW-1:0]              imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [DW-1:0]              imem_rdata,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [DW-1:0]              if_instr,
    output logic [AW-1:0]              if_pc,
    output logic [$clog2(DEPTH+1)-1:0] if_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            drop_pend_q, drop_pend_d;

    logic [AW-1:0]   pc_mem_q    [DEPTH];
    logic [DW-1:0]   instr_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            push;
    logic            pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            drop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            drop_pend_q <= drop_pend_d;
        end
    end

    // drop_pend remembers a flush seen while the request is still waiting for
    // its grant; the request itself must stay up until granted.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        drop_pend_d = drop_pend_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && (count_q < FULL)) begin
                    req_d       = 1'b1;
                    addr_d      = pc_in;
                    drop_pend_d = 1'b0;
                    state_d     = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (imem_gnt) begin
                    req_d       = 1'b0;
                    drop_pend_d = 1'b0;
                    state_d     = (flush || drop_pend_q) ? DROP : WAIT_RSP;
                end else if (flush) begin
                    drop_pend_d = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (imem_rvalid) begin
                    push    = !flush;
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = (count_q != '0) && if_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= addr_q;
                instr_mem_q[wr_ptr_q] <= imem_rdata;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign fetch_stall = !push;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign if_valid    = (count_q != '0);
    assign if_instr    = instr_mem_q[rd_ptr_q];
    assign if_pc       = pc_mem_q[rd_ptr_q];
    assign if_count    = count_q;

    a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset)
        !(push && !flush && (count_q == FULL)));

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          flush;
    logic          fetch_stall;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic [1:0]    if_count;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .flush       (flush),
        .fetch_stall (fetch_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_count    (if_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic do_reset(input logic [AW-1:0] pc, input logic gnt, input logic rdy);
        reset       = 1'b0;
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        imem_gnt    = gnt;
        if_ready    = rdy;
        pc_in       = pc;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int stall_lows;

    initial begin
        reset       = 1'b0;
        pc_in       = 32'h10;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if_ready    = 1'b0;
        repeat (3) tick();
        check_eq("rst_req",   imem_req,    0);
        check_eq("rst_addr",  imem_addr,   0);
        check_eq("rst_valid", if_valid,    0);
        check_eq("rst_count", if_count,    0);
        check_eq("rst_stall", fetch_stall, 1);

        // T1: reset hits while a response is outstanding
        reset = 1'b1;
        tick();
        check_eq("t1_req_up",  imem_req,  1);
        check_eq("t1_addr0",   imem_addr, 32'h10);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check_eq("t1_req_down", imem_req, 0);
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_eq("t1_rst_req",   imem_req,    0);
        check_eq("t1_rst_addr",  imem_addr,   0);
        check_eq("t1_rst_stall", fetch_stall, 1);
        tick();
        imem_rvalid = 1'b0;
        check_eq("t1_no_push_valid", if_valid, 0);
        check_eq("t1_no_push_count", if_count, 0);
        reset = 1'b1;
        pc_in = 32'h20;
        tick();
        check_eq("t1_first_req",  imem_req,  1);
        check_eq("t1_first_addr", imem_addr, 32'h20);

        // T2: back-to-back fetches with immediate grant, decode always ready
        do_reset(32'h0, 1'b1, 1'b1);
        stall_lows = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t2_req_%0d", i),  imem_req,  1);
            check_eq($sformatf("t2_addr_%0d", i), imem_addr, AW'(i));
            if (!fetch_stall) stall_lows++;
            tick();
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(AW'(i));
            #1;
            if (!fetch_stall) stall_lows++;
            tick();
            imem_rvalid = 1'b0;
            pc_in       = AW'(i + 1);
            #1;
            if (!fetch_stall) stall_lows++;
            check_eq($sformatf("t2_valid_%0d", i), if_valid, 1);
            check_eq($sformatf("t2_pc_%0d", i),    if_pc,    AW'(i));
            check_eq($sformatf("t2_instr_%0d", i), if_instr, word_at(AW'(i)));
        end
        check_eq("t2_stall_lows", stall_lows, 3);

        // T3: decode back-pressure fills the FIFO and stops issue
        do_reset(32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            tick();
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(AW'(i));
            #1;
            check_eq($sformatf("t3_stall_low_%0d", i), fetch_stall, 0);
            tick();
            imem_rvalid = 1'b0;
            pc_in       = AW'(i + 1);
            check_eq($sformatf("t3_count_%0d", i), if_count, AW'(i + 1));
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq($sformatf("t3_full_req_%0d", k),   imem_req,    0);
            check_eq($sformatf("t3_full_stall_%0d", k), fetch_stall, 1);
            check_eq($sformatf("t3_full_cnt_%0d", k),   if_count,    2);
        end
        check_eq("t3_head_pc0", if_pc, 0);
        if_ready = 1'b1;
        tick();
        check_eq("t3_cnt_after_pop1", if_count, 1);
        check_eq("t3_head_pc1",       if_pc,    1);
        check_eq("t3_no_req_yet",     imem_req, 0);
        tick();
        check_eq("t3_cnt_after_pop2", if_count,  0);
        check_eq("t3_resume_req",     imem_req,  1);
        check_eq("t3_resume_addr",    imem_addr, 2);

        // T4: slow grant, PC wandering; request must hold steady
        do_reset(32'h30, 1'b0, 1'b0);
        tick();
        check_eq("t4_req", imem_req, 1);
        for (int k = 0; k < 3; k++) begin
            pc_in = 32'h31 + AW'(k);
            tick();
            check_eq($sformatf("t4_hold_req_%0d", k),  imem_req,  1);
            check_eq($sformatf("t4_hold_addr_%0d", k), imem_addr, 32'h30);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check_eq("t4_req_drop", imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(32'h30);
        tick();
        imem_rvalid = 1'b0;
        check_eq("t4_pc",    if_pc,    32'h30);
        check_eq("t4_instr", if_instr, word_at(32'h30));

        // T5: flush with a buffered entry and a fetch in WAIT_RSP
        do_reset(32'h10, 1'b1, 1'b0);
        tick();
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(32'h10);
        tick();
        imem_rvalid = 1'b0;
        pc_in       = 32'h11;
        tick();
        check_eq("t5_second_addr", imem_addr, 32'h11);
        tick();
        check_eq("t5_cnt_before", if_count, 1);
        flush = 1'b1;
        pc_in = 32'h40;
        #1;
        check_eq("t5_flush_stall", fetch_stall, 1);
        tick();
        flush = 1'b0;
        check_eq("t5_cnt_cleared", if_count, 0);
        check_eq("t5_valid_low",   if_valid, 0);
        check_eq("t5_no_req",      imem_req, 0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        #1;
        check_eq("t5_late_stall", fetch_stall, 1);
        tick();
        imem_rvalid = 1'b0;
        check_eq("t5_late_dropped", if_count, 0);
        tick();
        check_eq("t5_redirect_req",  imem_req,  1);
        check_eq("t5_redirect_addr", imem_addr, 32'h40);

        // T6: flush coincides with the response
        do_reset(32'h50, 1'b1, 1'b0);
        tick();
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(32'h50);
        flush       = 1'b1;
        pc_in       = 32'h60;
        #1;
        check_eq("t6_stall", fetch_stall, 1);
        tick();
        imem_rvalid = 1'b0;
        flush       = 1'b0;
        check_eq("t6_count", if_count, 0);
        check_eq("t6_valid", if_valid, 0);
        check_eq("t6_req",   imem_req, 0);
        tick();
        check_eq("t6_next_req",  imem_req,  1);
        check_eq("t6_next_addr", imem_addr, 32'h60);

        // T7: flush while waiting for grant; request stays up, response dropped
        do_reset(32'h70, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        pc_in = 32'h80;
        tick();
        flush = 1'b0;
        check_eq("t7_req_kept",  imem_req,  1);
        check_eq("t7_addr_kept", imem_addr, 32'h70);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(32'h70);
        #1;
        check_eq("t7_drop_stall", fetch_stall, 1);
        tick();
        imem_rvalid = 1'b0;
        check_eq("t7_drop_count", if_count, 0);
        tick();
        check_eq("t7_next_addr", imem_addr, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
